// File: rtl/fsm_dwell_pkg.sv
// Shared constants and types for the fsm dwell controller.
// Used by fsm_dwell_cfg and fsm_dwell_ctrl.
package fsm_dwell_pkg;

  localparam int NUM_STATES = 7;
  localparam int STATE_W    = 3;
  localparam int DWELL_W    = 8;

  typedef logic [STATE_W-1:0] state_t;
  typedef logic [DWELL_W-1:0] dwell_t;

  localparam dwell_t DWELL_MAX = {DWELL_W{1'b1}};

  // Counter increment that sticks at DWELL_MAX so long dwells never wrap back to a short count.
  function automatic dwell_t sat_inc(input dwell_t v);
    if (v == DWELL_MAX) begin
      return v;
    end else begin
      return v + dwell_t'(1'b1);
    end
  endfunction

endpackage

// File: rtl/fsm_dwell_cfg.sv
// Per-state dwell register file with a single write port.
// Writes addressed beyond the last fsm state are dropped.
module fsm_dwell_cfg
  import fsm_dwell_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          cfg_we,
  input  state_t                        cfg_addr,
  input  dwell_t                        cfg_data,
  output dwell_t [NUM_STATES-1:0]       dwell
);

  logic                    addr_ok_s;
  dwell_t [NUM_STATES-1:0] dwell_r;

  // Address range check for the write port
  always_comb begin
    addr_ok_s = (int'(cfg_addr) < NUM_STATES);
  end

  // Dwell register write port
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dwell_r <= '0;
    end else begin
      for (int k = 0; k < NUM_STATES; k++) begin
        if (cfg_we && addr_ok_s && (cfg_addr == state_t'(k))) begin
          dwell_r[k] <= cfg_data;
        end
      end
    end
  end

  assign dwell = dwell_r;

endmodule

// File: rtl/fsm_dwell_ctrl.sv
// Dwell-time condition generator for the 7-state fsm: holds each go bit low until
// the programmed dwell has elapsed. Optional entry statistics under FSM_DWELL_STATS_EN.
module fsm_dwell_ctrl
  import fsm_dwell_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  state_t                state,
  input  logic                  cfg_we,
  input  state_t                cfg_addr,
  input  dwell_t                cfg_data,
  output logic [NUM_STATES-1:0] go,
  output logic                  err
`ifdef FSM_DWELL_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [15:0]           stat_entries
`endif
);

  state_t                  prev_r;
  dwell_t                  cnt_r;
  logic                    err_r;
  logic                    match_s;
  logic                    in_range_s;
  dwell_t                  eff_s;
  dwell_t [NUM_STATES-1:0] dwell_s;

  fsm_dwell_cfg u_cfg (
    .clock    (clock),
    .reset    (reset),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .dwell    (dwell_s)
  );

  // Effective time in the current state; a fresh entry counts as cycle 0
  always_comb begin
    match_s    = (state == prev_r);
    in_range_s = (int'(state) < NUM_STATES);
    if (match_s) begin
      eff_s = cnt_r;
    end else begin
      eff_s = '0;
    end
  end

  // Advance conditions; combinational so the fsm sees them at the same edge
  always_comb begin
    go = '0;
    if (reset && en && in_range_s) begin
      for (int k = 0; k < NUM_STATES; k++) begin
        go[k] = (state == state_t'(k)) && (eff_s >= dwell_s[k]);
      end
    end else begin
      go = '0;
    end
  end

  // Dwell counter and last-state tracker, frozen while en is low
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev_r <= '0;
      cnt_r  <= '0;
    end else if (en) begin
      prev_r <= state;
      cnt_r  <= match_s ? sat_inc(cnt_r) : dwell_t'(1'b1);
    end
  end

  // Sticky out-of-range state flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_r <= 1'b0;
    end else if (!in_range_s) begin
      err_r <= 1'b1;
    end
  end

  assign err = err_r;

`ifdef FSM_DWELL_STATS_EN
  logic [15:0] stat_r;

  // Saturating count of valid state entries; clear wins over increment
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_r <= 16'h0000;
    end else if (stat_clr) begin
      stat_r <= 16'h0000;
    end else if (en && !match_s && in_range_s && (stat_r != 16'hFFFF)) begin
      stat_r <= stat_r + 16'h0001;
    end
  end

  assign stat_entries = stat_r;
`endif

endmodule

// File: tb/tb_fsm_dwell_ctrl.sv
// Self-checking bench for fsm_dwell_ctrl: a small fsm model closes the loop on go,
// and a history-based reference predicts go/err every cycle.
module tb_fsm_dwell_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] state;
  logic       cfg_we;
  logic [2:0] cfg_addr;
  logic [7:0] cfg_data;
  logic [6:0] go;
  logic       err;
`ifdef FSM_DWELL_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_entries;
`endif

  always #5 clock = ~clock;

  fsm_dwell_ctrl dut (
    .clock    (clock),
    .reset    (reset),
    .en       (en),
    .state    (state),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .go       (go),
    .err      (err)
`ifdef FSM_DWELL_STATS_EN
    ,
    .stat_clr     (stat_clr),
    .stat_entries (stat_entries)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference: dwell table, history of enabled samples, sticky err, entry count
  logic [7:0] m_dwell [7];
  logic [2:0] hist [$];
  bit         m_err;
  int         m_stat;
  bit         fsm_mode;
  logic [6:0] g_chk;
  logic [2:0] s_chk;

  function automatic int run_len(input logic [2:0] s);
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] != s || n == 255) break;
      n++;
    end
    return n;
  endfunction

  function automatic logic [6:0] exp_go();
    logic [6:0] one = 7'd1;
    if (reset !== 1'b1 || en !== 1'b1 || state > 3'd6) return 7'd0;
    if (run_len(state) >= int'(m_dwell[state])) return one << state;
    return 7'd0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 7; i++) m_dwell[i] = 8'd0;
    hist.delete();
    m_err  = 1'b0;
    m_stat = 0;
  endfunction

  task automatic tick();
    logic [2:0] prev;
    @(negedge clock);
    s_chk = state;
    g_chk = go;
    checks++;
    if (go !== exp_go()) begin
      errors++;
      $display("FAIL go_cycle: t=%0t state=%0d en=%0b got=%b want=%b", $time, state, en, go, exp_go());
    end
    checks++;
    if (err !== m_err) begin
      errors++;
      $display("FAIL err_cycle: t=%0t got=%b want=%b", $time, err, m_err);
    end
`ifdef FSM_DWELL_STATS_EN
    checks++;
    if (stat_entries !== 16'(m_stat)) begin
      errors++;
      $display("FAIL stat_cycle: t=%0t got=%0d want=%0d", $time, stat_entries, m_stat);
    end
`endif
    @(posedge clock);
    if (reset === 1'b1) begin
      prev = (hist.size() > 0) ? hist[hist.size() - 1] : 3'd0;
`ifdef FSM_DWELL_STATS_EN
      if (stat_clr) m_stat = 0;
      else if (en && state != prev && state <= 3'd6 && m_stat < 65535) m_stat++;
`endif
      if (en) begin
        hist.push_back(state);
        if (hist.size() > 300) void'(hist.pop_front());
      end
      if (state > 3'd6) m_err = 1'b1;
      if (cfg_we && cfg_addr <= 3'd6) m_dwell[cfg_addr] = cfg_data;
    end
    #1;
    cfg_we = 1'b0;
`ifdef FSM_DWELL_STATS_EN
    stat_clr = 1'b0;
`endif
    if (fsm_mode && reset === 1'b1 && g_chk[state]) state = (state == 3'd6) ? 3'd0 : state + 3'd1;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
  endtask

  task automatic test_reset();
    fsm_mode = 1'b0;
    reset = 1'b0; en = 1'b1; state = 3'd0;
    cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 8'd0;
`ifdef FSM_DWELL_STATS_EN
    stat_clr = 1'b0;
`endif
    model_reset();
    repeat (16) tick();
    checks++;
    if (go !== 7'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: go=%b err=%b want go=0 err=0", go, err);
    end
    reset = 1'b1;
    fsm_mode = 1'b1;
    for (int i = 0; i < 21; i++) begin
      tick();
      checks++;
      if (g_chk !== (7'd1 << s_chk)) begin
        errors++;
        $display("FAIL free_run_onehot: state=%0d go=%b", s_chk, g_chk);
      end
    end
    checks++;
    if (state !== 3'd0) begin
      errors++;
      $display("FAIL free_run_position: state=%0d want 0", state);
    end
  endtask

  task automatic measure_hold(input logic [2:0] s, input int want_hold, input int bound);
    int guard = 0;
    int hold  = 0;
    int goes  = 0;
    do begin tick(); guard++; end while (s_chk != s && guard < bound);
    hold = 1;
    goes = int'(g_chk[s]);
    while (guard < bound) begin
      tick();
      guard++;
      if (s_chk != s) break;
      hold++;
      goes += int'(g_chk[s]);
    end
    checks++;
    if (guard >= bound || hold != want_hold || goes != 1) begin
      errors++;
      $display("FAIL hold_state%0d: held=%0d go_cycles=%0d want held=%0d go_cycles=1", s, hold, goes, want_hold);
    end
    checks++;
    if (g_chk !== (7'd1 << s_chk)) begin
      errors++;
      $display("FAIL next_state_single: state=%0d go=%b", s_chk, g_chk);
    end
  endtask

  task automatic test_dwell_hold();
    cfg_write(3'd2, 8'd3);
    tick();
    measure_hold(3'd2, 4, 40);
  endtask

  task automatic test_saturate();
    cfg_write(3'd4, 8'd255);
    tick();
    measure_hold(3'd4, 256, 400);
    cfg_write(3'd4, 8'd0);
    tick();
  endtask

  task automatic test_enable();
    int guard = 0;
    int hold2 = 0;
    do begin tick(); guard++; end while (s_chk != 3'd2 && guard < 20);
    tick();
    en = 1'b0;
    cfg_write(3'd7, 8'd200);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (g_chk !== 7'd0 || s_chk !== 3'd2) begin
        errors++;
        $display("FAIL en_low_hold: state=%0d go=%b want state=2 go=0", s_chk, g_chk);
      end
    end
    en = 1'b1;
    while (guard < 40) begin
      tick();
      guard++;
      if (s_chk != 3'd2) break;
      hold2++;
    end
    checks++;
    if (hold2 != 2) begin
      errors++;
      $display("FAIL en_resume_remaining: cycles=%0d want 2", hold2);
    end
    do begin tick(); guard++; end while (s_chk != 3'd0 && guard < 60);
    checks++;
    if (g_chk !== 7'd1) begin
      errors++;
      $display("FAIL addr7_ignored: state0 go=%b want 0000001", g_chk);
    end
  endtask

  task automatic test_err_and_reset();
    int guard = 0;
    fsm_mode = 1'b0;
    state = 3'd7;
    tick();
    checks++;
    if (g_chk !== 7'd0) begin
      errors++;
      $display("FAIL oob_go: go=%b want 0", g_chk);
    end
    state = 3'd3;
    tick();
    tick();
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err=%b want 1", err);
    end
    fsm_mode = 1'b1;
    cfg_write(3'd5, 8'd50);
    tick();
    do begin tick(); guard++; end while (s_chk != 3'd5 && guard < 20);
    repeat (3) tick();
    checks++;
    if (g_chk !== 7'd0) begin
      errors++;
      $display("FAIL mid_dwell_go: go=%b want 0", g_chk);
    end
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (go !== 7'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: go=%b err=%b want 0 0", go, err);
    end
    model_reset();
    repeat (2) tick();
    reset = 1'b1;
    #1;
    checks++;
    if (go !== (7'd1 << state)) begin
      errors++;
      $display("FAIL dwell_cleared: state=%0d go=%b", state, go);
    end
  endtask

  task automatic test_random();
    fsm_mode = 1'b1;
    for (int i = 0; i < 800; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) cfg_write(3'($urandom_range(0, 7)), 8'($urandom_range(0, 4)));
      if (state == 3'd7) state = 3'($urandom_range(0, 6));
      else if ($urandom_range(0, 99) == 0) state = 3'($urandom_range(0, 7));
      tick();
    end
    if (state == 3'd7) state = 3'd0;
    en = 1'b1;
  endtask

`ifdef FSM_DWELL_STATS_EN
  task automatic test_stats();
    fsm_mode = 1'b0;
    reset = 1'b0;
    state = 3'd6;
    model_reset();
    repeat (2) tick();
    reset = 1'b1;
    en = 1'b1;
    stat_clr = 1'b1;
    tick();
    state = 3'd0;
    fsm_mode = 1'b1;
    repeat (21) tick();
    checks++;
    if (stat_entries !== 16'd21) begin
      errors++;
      $display("FAIL stat_three_loops: got=%0d want 21", stat_entries);
    end
    stat_clr = 1'b1;
    tick();
    checks++;
    if (stat_entries !== 16'd0) begin
      errors++;
      $display("FAIL stat_clear: got=%0d want 0", stat_entries);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_dwell_hold();
    test_saturate();
    test_enable();
    test_err_and_reset();
    test_random();
`ifdef FSM_DWELL_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
